// File: rtl/conv_engine_pkg.sv
// ============================================================================
//  Module   : conv_pkg
//  Purpose  : Shared types and elaboration-time helpers for the convolution
//             engine: FSM state encoding, ceil-log2 and the derived output
//             map / accumulator widths.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package conv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MAC   = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Ceiling log2; returns 0 for values <= 1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // Number of window positions along one axis.
  function automatic int calc_out_h(input int img_h, input int k, input int stride);
    return (img_h - k) / stride + 1;
  endfunction

  function automatic int calc_out_w(input int img_w, input int k, input int stride);
    return (img_w - k) / stride + 1;
  endfunction

  // Products of two (DATA_W+1)-bit operands need 2*DATA_W+2 bits; K*K of
  // them summed need clog2(K*K) more, so the accumulator can never wrap.
  function automatic int calc_acc_w(input int data_w, input int k);
    return 2 * data_w + 2 + clog2(k * k);
  endfunction

endpackage

`default_nettype wire

// File: rtl/conv_engine_if.sv
// ============================================================================
//  Module   : conv_engine_if
//  Purpose  : Bundles the weight-load port, run control and result map of the
//             convolution engine.
//  Signals  : w_valid/w_data/w_ready - serial weight load (row-major taps)
//             start/signed_mode/relu_en/in_map - run request, sampled at start
//             conv_out/busy/done - registered output map and run status
//  Modports : master (requester side), slave (engine side)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface conv_engine_if #(
  parameter int DATA_W = 8,
  parameter int IMG_H  = 4,
  parameter int IMG_W  = 4,
  parameter int K      = 3,
  parameter int STRIDE = 1
);
  import conv_pkg::*;

  localparam int OUT_H = calc_out_h(IMG_H, K, STRIDE);
  localparam int OUT_W = calc_out_w(IMG_W, K, STRIDE);

  logic                            w_valid;
  logic [DATA_W-1:0]               w_data;
  logic                            w_ready;
  logic                            start;
  logic                            signed_mode;
  logic                            relu_en;
  logic [IMG_H*IMG_W*DATA_W-1:0]   in_map;
  logic [OUT_H*OUT_W*DATA_W-1:0]   conv_out;
  logic                            busy;
  logic                            done;

  modport master (
    output w_valid, w_data, start, signed_mode, relu_en, in_map,
    input  w_ready, conv_out, busy, done
  );

  modport slave (
    input  w_valid, w_data, start, signed_mode, relu_en, in_map,
    output w_ready, conv_out, busy, done
  );

endinterface

`default_nettype wire

// File: rtl/conv_engine_postproc.sv
// ============================================================================
//  Module   : conv_postproc
//  Purpose  : Combinational result stage: arithmetic right shift, optional
//             ReLU, then saturation to the signed or unsigned DATA_W range.
//  Ports    : acc         in  ACC_W  signed accumulator value
//             signed_mode in  1      1 = saturate to signed range
//             relu_en     in  1      1 = negatives become 0
//             result      out DATA_W saturated result
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_postproc #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 22,
  parameter int SHIFT  = 0
) (
  input  logic signed [ACC_W-1:0] acc,
  input  logic                    signed_mode,
  input  logic                    relu_en,
  output logic [DATA_W-1:0]       result
);

  localparam logic signed [ACC_W-1:0] c_smax = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] c_smin = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] c_umax = {{(ACC_W-DATA_W){1'b0}}, {DATA_W{1'b1}}};

  logic signed [ACC_W-1:0] w_shifted;
  logic signed [ACC_W-1:0] w_relu;

  always_comb begin
    w_shifted = acc >>> SHIFT;
    w_relu    = (relu_en && w_shifted[ACC_W-1]) ? '0 : w_shifted;
    result    = w_relu[DATA_W-1:0];
    if (signed_mode) begin
      if (w_relu > c_smax)      result = {1'b0, {(DATA_W-1){1'b1}}};
      else if (w_relu < c_smin) result = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      if (w_relu[ACC_W-1])      result = '0;
      else if (w_relu > c_umax) result = {DATA_W{1'b1}};
    end
  end

endmodule

`default_nettype wire

// File: rtl/conv_engine.sv
// ============================================================================
//  Module   : conv_engine
//  Purpose  : Time-multiplexed 2-D convolution: one multiply-accumulate per
//             cycle over a latched input map, K*K taps per output followed by
//             one write-back cycle, results post-processed into conv_out.
//  Ports    : clk  in  1  clock
//             rst  in  1  asynchronous active-high reset
//             bus  conv_engine_if.slave - weights, run control, output map
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_engine
  import conv_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int IMG_H  = 4,
  parameter int IMG_W  = 4,
  parameter int K      = 3,
  parameter int STRIDE = 1,
  parameter int SHIFT  = 0
) (
  input  logic          clk,
  input  logic          rst,
  conv_engine_if.slave  bus
);

  localparam int OUT_H  = calc_out_h(IMG_H, K, STRIDE);
  localparam int OUT_W  = calc_out_w(IMG_W, K, STRIDE);
  localparam int ACC_W  = calc_acc_w(DATA_W, K);
  localparam int TAPS   = K * K;
  localparam int OUTS   = OUT_H * OUT_W;
  localparam int NPIX   = IMG_H * IMG_W;
  localparam int KI_W   = (TAPS > 1) ? clog2(TAPS) : 1;
  localparam int OI_W   = (OUTS > 1) ? clog2(OUTS) : 1;
  localparam int PIX_W  = (NPIX > 1) ? clog2(NPIX) : 1;
  localparam int OP_W   = DATA_W + 1;
  localparam int PROD_W = 2 * OP_W;

  localparam logic [KI_W-1:0] c_last_tap = KI_W'(TAPS - 1);
  localparam logic [OI_W-1:0] c_last_out = OI_W'(OUTS - 1);

  state_t                  r_state;
  state_t                  w_next_state;
  logic [DATA_W-1:0]       r_weights [TAPS];
  logic [KI_W-1:0]         r_wptr;
  logic [KI_W-1:0]         r_ki;
  logic [OI_W-1:0]         r_oi;
  logic [NPIX*DATA_W-1:0]  r_map;
  logic                    r_signed;
  logic                    r_relu;
  logic signed [ACC_W-1:0] r_acc;
  logic [DATA_W-1:0]       r_slots [OUTS];
  logic                    r_busy;
  logic                    r_done;

  logic                    w_in_idle;
  logic                    w_accept;
  logic                    w_load;
  logic                    w_mac;
  logic                    w_write;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_in_idle    = 1'b0;
    w_mac        = 1'b0;
    w_write      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_in_idle = 1'b1;
        if (bus.start) w_next_state = ST_MAC;
      end
      ST_MAC: begin
        w_mac = 1'b1;
        if (r_ki == c_last_tap) w_next_state = ST_WRITE;
      end
      ST_WRITE: begin
        w_write      = 1'b1;
        w_next_state = (r_oi == c_last_out) ? ST_DONE : ST_MAC;
      end
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  assign w_accept = w_in_idle && bus.start;
  assign w_load   = w_in_idle && bus.w_valid;

  // ------------------------------------------------ window index decode
  logic [DATA_W-1:0] w_pixels [NPIX];
  logic [PIX_W-1:0]  w_pix;
  int                w_ky, w_kx, w_oy, w_ox;

  for (genvar p = 0; p < NPIX; p++) begin : g_pix
    assign w_pixels[p] = r_map[p*DATA_W +: DATA_W];
  end

  always_comb begin
    w_ky  = int'(r_ki) / K;
    w_kx  = int'(r_ki) % K;
    w_oy  = int'(r_oi) / OUT_W;
    w_ox  = int'(r_oi) % OUT_W;
    w_pix = PIX_W'((w_oy * STRIDE + w_ky) * IMG_W + w_ox * STRIDE + w_kx);
  end

  // ---------------------------------------------------------------- MAC
  logic [DATA_W-1:0]        w_wt;
  logic [DATA_W-1:0]        w_px;
  logic signed [OP_W-1:0]   w_wop;
  logic signed [OP_W-1:0]   w_pop;
  logic signed [PROD_W-1:0] w_prod;
  logic [DATA_W-1:0]        w_result;

  assign w_wt   = r_weights[r_ki];
  assign w_px   = w_pixels[w_pix];
  // One extra bit lets unsigned operands ride through a signed multiplier.
  assign w_wop  = r_signed ? {w_wt[DATA_W-1], w_wt} : {1'b0, w_wt};
  assign w_pop  = r_signed ? {w_px[DATA_W-1], w_px} : {1'b0, w_px};
  assign w_prod = PROD_W'(w_wop) * PROD_W'(w_pop);

  conv_postproc #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .SHIFT  (SHIFT)
  ) u_postproc (
    .acc         (r_acc),
    .signed_mode (r_signed),
    .relu_en     (r_relu),
    .result      (w_result)
  );

  // ---------------------------------------------------- weight registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int t = 0; t < TAPS; t++) r_weights[t] <= '0;
    end else if (w_load) begin
      r_weights[r_wptr] <= bus.w_data;
    end
  end

  // A beat coinciding with start is still written; start then rewinds wptr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_wptr <= '0;
    else if (w_accept) r_wptr <= '0;
    else if (w_load)   r_wptr <= (r_wptr == c_last_tap) ? '0 : r_wptr + 1'b1;
  end

  // ------------------------------------------------------------ datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ki     <= '0;
      r_oi     <= '0;
      r_map    <= '0;
      r_signed <= 1'b0;
      r_relu   <= 1'b0;
      r_acc    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      for (int s = 0; s < OUTS; s++) r_slots[s] <= '0;
    end else begin
      r_done <= (r_state == ST_DONE);
      if (r_state == ST_DONE) r_busy <= 1'b0;
      if (w_accept) begin
        r_map    <= bus.in_map;
        r_signed <= bus.signed_mode;
        r_relu   <= bus.relu_en;
        r_acc    <= '0;
        r_ki     <= '0;
        r_oi     <= '0;
        r_busy   <= 1'b1;
      end
      if (w_mac) begin
        r_acc <= r_acc + ACC_W'(w_prod);
        if (r_ki != c_last_tap) r_ki <= r_ki + 1'b1;
      end
      if (w_write) begin
        r_slots[r_oi] <= w_result;
        r_acc         <= '0;
        r_ki          <= '0;
        if (r_oi != c_last_out) r_oi <= r_oi + 1'b1;
      end
    end
  end

  // ------------------------------------------------------------- outputs
  for (genvar s = 0; s < OUTS; s++) begin : g_out
    assign bus.conv_out[s*DATA_W +: DATA_W] = r_slots[s];
  end

  assign bus.w_ready = w_in_idle;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;

endmodule

`default_nettype wire

// File: tb/tb_conv_engine.sv
// ============================================================================
//  Module   : tb_conv_engine
//  Purpose  : Scoreboard bench for conv_engine. Two instances: the default
//             4x4/K3/stride-1 engine and a 6x6/K3/stride-2/shift-2 engine.
//             Stimulus pushes hand-computed maps; monitors check on done.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_conv_engine;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  conv_engine_if #(.DATA_W(8), .IMG_H(4), .IMG_W(4), .K(3), .STRIDE(1)) bus_a ();
  conv_engine_if #(.DATA_W(8), .IMG_H(6), .IMG_W(6), .K(3), .STRIDE(2)) bus_b ();

  conv_engine #(.DATA_W(8), .IMG_H(4), .IMG_W(4), .K(3), .STRIDE(1), .SHIFT(0)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  conv_engine #(.DATA_W(8), .IMG_H(6), .IMG_W(6), .K(3), .STRIDE(2), .SHIFT(2)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  typedef struct {
    logic [31:0] map;
    int          lat;
    int          busy;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t e_a, e_b;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int acc_a, acc_b;
  int base_a, base_b;
  int busy_cnt_a = 0;
  int busy_cnt_b = 0;
  logic [7:0] wbuf [9];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ------------------------------------------------------------ monitors
  always @(negedge clk) begin
    if (bus_a.busy) busy_cnt_a++;
    if (bus_a.done) begin
      if (q_a.size() == 0) begin
        check("a_unexpected_done", 64'(bus_a.done), 64'd0);
      end else begin
        e_a = q_a.pop_front();
        check("a_conv_out", 64'(bus_a.conv_out), 64'(e_a.map));
        check("a_latency", 64'(cyc - acc_a), 64'(e_a.lat));
        check("a_busy_cycles", 64'(busy_cnt_a - base_a), 64'(e_a.busy));
      end
    end
  end

  always @(negedge clk) begin
    if (bus_b.busy) busy_cnt_b++;
    if (bus_b.done) begin
      if (q_b.size() == 0) begin
        check("b_unexpected_done", 64'(bus_b.done), 64'd0);
      end else begin
        e_b = q_b.pop_front();
        check("b_conv_out", 64'(bus_b.conv_out), 64'(e_b.map));
        check("b_latency", 64'(cyc - acc_b), 64'(e_b.lat));
        check("b_busy_cycles", 64'(busy_cnt_b - base_b), 64'(e_b.busy));
      end
    end
  end

  // ------------------------------------------------------------- helpers
  function automatic logic [127:0] lin4();
    logic [127:0] m;
    m = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        m[(r*4+c)*8 +: 8] = 8'(10*r + c);
    return m;
  endfunction

  function automatic logic [287:0] lin6();
    logic [287:0] m;
    m = '0;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++)
        m[(r*6+c)*8 +: 8] = 8'(10*r + c);
    return m;
  endfunction

  task automatic set_w(input logic [7:0] v);
    for (int i = 0; i < 9; i++) wbuf[i] = v;
  endtask

  task automatic load_a(input int n);
    for (int i = 0; i < n; i++) begin
      bus_a.w_valid = 1'b1;
      bus_a.w_data  = wbuf[i];
      @(posedge clk); #1;
    end
    bus_a.w_valid = 1'b0;
  endtask

  task automatic load_b(input int n);
    for (int i = 0; i < n; i++) begin
      bus_b.w_valid = 1'b1;
      bus_b.w_data  = wbuf[i];
      @(posedge clk); #1;
    end
    bus_b.w_valid = 1'b0;
  endtask

  task automatic wait_a();
    int i;
    i = 0;
    while (q_a.size() != 0 && i < 200) begin
      @(posedge clk);
      i++;
    end
    if (q_a.size() != 0) begin
      check("a_done_timeout", 64'(q_a.size()), 64'd0);
      q_a.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_b();
    int i;
    i = 0;
    while (q_b.size() != 0 && i < 200) begin
      @(posedge clk);
      i++;
    end
    if (q_b.size() != 0) begin
      check("b_done_timeout", 64'(q_b.size()), 64'd0);
      q_b.delete();
    end
    @(posedge clk); #1;
  endtask

  // Inputs are scrambled right after acceptance to prove they were latched.
  // With disturb set, start and a weight beat are pulsed in the middle of
  // the run; neither may change the result or the timing.
  task automatic run_a(input logic [127:0] map, input logic sm, input logic relu,
                       input logic [31:0] exp_map, input bit disturb);
    exp_t e;
    bus_a.in_map      = map;
    bus_a.signed_mode = sm;
    bus_a.relu_en     = relu;
    bus_a.start       = 1'b1;
    base_a            = busy_cnt_a;
    @(posedge clk); #1;
    acc_a             = cyc;
    bus_a.start       = 1'b0;
    bus_a.w_valid     = 1'b0;
    bus_a.in_map      = ~map;
    bus_a.signed_mode = ~sm;
    bus_a.relu_en     = ~relu;
    e.map  = exp_map;
    e.lat  = 41;
    e.busy = 41;
    q_a.push_back(e);
    if (disturb) begin
      repeat (10) @(posedge clk);
      #1;
      bus_a.start   = 1'b1;
      bus_a.w_valid = 1'b1;
      bus_a.w_data  = 8'h5A;
      @(posedge clk); #1;
      bus_a.start   = 1'b0;
      bus_a.w_valid = 1'b0;
    end
    wait_a();
  endtask

  task automatic run_b(input logic [287:0] map, input logic sm, input logic relu,
                       input logic [31:0] exp_map);
    exp_t e;
    bus_b.in_map      = map;
    bus_b.signed_mode = sm;
    bus_b.relu_en     = relu;
    bus_b.start       = 1'b1;
    base_b            = busy_cnt_b;
    @(posedge clk); #1;
    acc_b             = cyc;
    bus_b.start       = 1'b0;
    bus_b.in_map      = ~map;
    e.map  = exp_map;
    e.lat  = 41;
    e.busy = 41;
    q_b.push_back(e);
    wait_b();
  endtask

  // ------------------------------------------------------------ stimulus
  initial begin
    rst = 1'b1;
    bus_a.w_valid = 1'b0; bus_a.w_data = '0; bus_a.start = 1'b0;
    bus_a.signed_mode = 1'b0; bus_a.relu_en = 1'b0; bus_a.in_map = '0;
    bus_b.w_valid = 1'b0; bus_b.w_data = '0; bus_b.start = 1'b0;
    bus_b.signed_mode = 1'b0; bus_b.relu_en = 1'b0; bus_b.in_map = '0;

    repeat (3) @(negedge clk);
    check("reset_conv_out", 64'(bus_a.conv_out), 64'd0);
    check("reset_busy", 64'(bus_a.busy), 64'd0);
    check("reset_done", 64'(bus_a.done), 64'd0);
    check("reset_w_ready", 64'(bus_a.w_ready), 64'd1);
    check("reset_b_w_ready", 64'(bus_b.w_ready), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Identity kernel, unsigned: centre pixels 11,12,21,22.
    set_w(8'd0); wbuf[4] = 8'd1;
    load_a(9);
    run_a(lin4(), 1'b0, 1'b0, 32'h16150C0B, 1'b0);
    // Mid-run start and weight beat must be ignored, this run and the next.
    run_a(lin4(), 1'b0, 1'b0, 32'h16150C0B, 1'b1);
    run_a(lin4(), 1'b0, 1'b0, 32'h16150C0B, 1'b0);

    // All ones -> 9; then 255*255*9 saturates to 255.
    set_w(8'd1); load_a(9);
    run_a({16{8'd1}}, 1'b0, 1'b0, 32'h09090909, 1'b0);
    set_w(8'hFF); load_a(9);
    run_a({16{8'hFF}}, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b0);

    // Signed: -1 * 100 * 9 = -900 -> -128; with ReLU -> 0.
    run_a({16{8'd100}}, 1'b1, 1'b0, 32'h80808080, 1'b0);
    run_a({16{8'd100}}, 1'b1, 1'b1, 32'h00000000, 1'b0);

    // Signed, in range: 2*p(y,x) - p(y+2,x+2) = -22,-21,-12,-11.
    set_w(8'd0); wbuf[0] = 8'd2; wbuf[8] = 8'hFF;
    load_a(9);
    run_a(lin4(), 1'b1, 1'b0, 32'hF5F4EBEA, 1'b0);

    // Unsigned taps (0,1)=3, (1,0)=1: 13,17,53,57.
    set_w(8'd0); wbuf[1] = 8'd3; wbuf[3] = 8'd1;
    load_a(9);
    run_a(lin4(), 1'b0, 1'b0, 32'h3935110D, 1'b0);

    // Beat coincident with start lands in tap 0: 2*p + centre = 11,14,41,44.
    set_w(8'd0); wbuf[4] = 8'd1;
    load_a(9);
    bus_a.w_valid = 1'b1;
    bus_a.w_data  = 8'd2;
    run_a(lin4(), 1'b0, 1'b0, 32'h2C290E0B, 1'b0);

    // Four zero beats restore identity; after start the next beat is tap 0.
    set_w(8'd0);
    load_a(4);
    run_a(lin4(), 1'b0, 1'b0, 32'h16150C0B, 1'b0);
    wbuf[0] = 8'd5;
    load_a(1);
    run_a(lin4(), 1'b0, 1'b0, 32'h4D47110B, 1'b0);

    // Reset about 20 cycles into a run.
    set_w(8'd1); load_a(9);
    bus_a.in_map = lin4(); bus_a.signed_mode = 1'b0; bus_a.relu_en = 1'b0;
    bus_a.start = 1'b1;
    @(posedge clk); #1;
    bus_a.start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    check("pre_reset_busy", 64'(bus_a.busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_conv_out", 64'(bus_a.conv_out), 64'd0);
    check("midrst_busy", 64'(bus_a.busy), 64'd0);
    check("midrst_w_ready", 64'(bus_a.w_ready), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    check("post_rst_busy", 64'(bus_a.busy), 64'd0);
    check("post_rst_conv_out", 64'(bus_a.conv_out), 64'd0);
    // Only tap 0 reloaded; the rest must have been cleared: outputs = p(y,x).
    set_w(8'd0); wbuf[0] = 8'd1;
    load_a(1);
    run_a(lin4(), 1'b0, 1'b0, 32'h0B0A0100, 1'b0);

    // 6x6, stride 2, shift 2: window sums 99,117,279,297.
    set_w(8'd1); load_b(9);
    run_b(lin6(), 1'b0, 1'b0, 32'h4A451D18);
    set_w(8'hFF); load_b(9);
    run_b(lin6(), 1'b1, 1'b0, 32'hB5BAE2E7);
    run_b(lin6(), 1'b1, 1'b1, 32'h00000000);

    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", n_total, n_bad);
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/conv_engine.md
# conv_engine

Parametrised, time-multiplexed 2-D convolution engine; successor to the fixed 3x3-over-4x4 convolution PE in the controller path. It supports these generalisations:
- Image size, kernel size and stride are parameters.
- Weights load serially over a valid/ready port.
- Signed or unsigned arithmetic and optional ReLU are selected at run time.
- Results pass through a shift/saturate stage.

The engine sits beside the systolic array controller and produces a full output map per `start`, using one multiply-accumulate per cycle.

## Interface
- `DATA_W`, 8: operand and output width
- `IMG_H`, 4: input map rows
- `IMG_W`, 4: input map columns
- `K`, 3: square kernel size
- `STRIDE`, 1: window step, rows and columns
- `SHIFT`, 0: arithmetic right shift applied to the accumulator before saturation
- Derived (localparam):
  - `OUT_H=(IMG_H-K)/STRIDE+1`, `OUT_W=(IMG_W-K)/STRIDE+1`
  - `ACC_W=2*DATA_W+2+clog2(K*K)`

- `clk` in 1: clock
- `rst` in 1: asynchronous, active-high reset
- `w_valid` in 1: weight beat valid
- `w_data` in DATA_W: weight, row-major order, tap 0 = (0,0)
- `w_ready` out 1: high in IDLE only
- `start` in 1: begin convolution (accepted in IDLE only)
- `signed_mode` in 1: sampled at start; 1 = two's-complement operands
- `relu_en` in 1: sampled at start; 1 = clamp negatives to 0
- `in_map` in IMG_H*IMG_W*DATA_W: pixel (r,c) at `[(r*IMG_W+c)*DATA_W +: DATA_W]`; latched at start
- `conv_out` out OUT_H*OUT_W*DATA_W: output (r,c) at `[(r*OUT_W+c)*DATA_W +: DATA_W]`; registered
- `busy` out 1: high from the start acceptance edge until done
- `done` out 1: one-cycle pulse when the map is complete

## Operation
- **Reset values:** all outputs 0 except `w_ready`, which is 1; weights, pointers and accumulator are 0; state is IDLE.
- **Weight load:** in IDLE, each `w_valid` beat writes tap `wptr`, then `wptr` increments and wraps K*K-1 -> 0. Weights persist across runs until overwritten.
- **Start acceptance:** in IDLE, `start` latches `in_map`, `signed_mode` and `relu_en`, clears the accumulator, sets `oi=0`, `ki=0` and `wptr=0`, and enters MAC.
- **FSM states:** IDLE, MAC, WRITE, DONE.
  - **MAC:** each cycle, `acc += w[ki] * in[oy*STRIDE+ky][ox*STRIDE+kx]`. After `ki=K*K-1` the FSM moves to WRITE.
  - **WRITE:** post-process `acc`, store it in slot `oi`, clear `acc`, reset `ki` to 0. If `oi` is the last output, go to DONE; otherwise increment `oi` and return to MAC.
  - **DONE:** pulse `done`, drop `busy`, return to IDLE.
- **Arithmetic:**
  - Unsigned mode zero-extends operands to DATA_W+1 bits; signed mode sign-extends them.
  - Products are signed; the accumulator is signed ACC_W and never overflows.
- **Post-process:**
  - Arithmetic `>>> SHIFT`.
  - If `relu_en`, negatives become 0.
  - Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1] in signed mode, or [0, 2^DATA_W-1] in unsigned mode.
- **conv_out update:** slots update progressively during a run and hold their values until overwritten. Slots not yet written in the current run keep their previous-run values.

## Timing
- **Latency:** `done` is high in the cycle starting OUT_H*OUT_W*(K*K+1)+1 cycles after the start-accept edge; with defaults this is 41.
- **Throughput:** one MAC per cycle; no stalls.
- **`start` while busy:** ignored, with no effect on the run.
- **`w_valid` while busy:** ignored, since `w_ready` is 0.
- **`start` and `w_valid` in the same IDLE cycle:** the beat is written, then `wptr` resets to 0. The run uses the updated weight.
- **`start` asserted in the DONE cycle:** ignored; `start` is accepted from the next IDLE cycle.
- **`rst` mid-run:** returns immediately to the reset values. No `done` is produced and `conv_out` is cleared.

## Structure
- Package `conv_pkg` holds:
  - the state enum (IDLE/MAC/WRITE/DONE);
  - a `clog2` function;
  - the derived-width functions for OUT_H, OUT_W and ACC_W.
- Sub-module `conv_postproc` is combinational. It takes `acc`, `signed_mode`, `relu_en` and `SHIFT`, and produces the saturated DATA_W result. It is unit-testable on its own.
- Top level contains:
  - the FSM;
  - the `ki`/`oi` counters with window-index decode;
  - the weight register file;
  - the latched input map;
  - the MAC.

## Test plan
- **Identity kernel, unsigned, defaults:** load weights with centre=1 and all others 0; `in_map` pixel value = 10*r+c. Expect outputs 11,12,21,22, `done` at cycle 41, and `busy` high for 41 cycles.
- **All-ones kernel and all-ones input:** every output is 9. Then run with all pixels 255, unsigned: 585225 saturates to 255.
- **Signed mode:** weights all -1, pixels 100. Expect -900, which saturates to -128 (0x80). With `relu_en=1`, expect 0.
- **Parameters `IMG_H=IMG_W=6`, `K=3`, `STRIDE=2`, `SHIFT=2`:** a 2x2 output map; results match the reference model with the accumulator shifted right by 2; latency is 41.
- **Handshake edges:**
  - `start` pulsed mid-run: ignored.
  - `w_valid` mid-run: no weight change.
  - `start` and `w_valid` together: the new weight is used.
  - Partial weight load (4 beats) followed by `start`: the next load begins at tap 0.
- **Reset at cycle 20 of a run:** `conv_out`=0, `busy`=0, no `done`, and weights are cleared. A fresh run then completes normally.
